// File: rtl/uart_rx_cmd_ctrl_if.sv
// uart_rx_cmd_ctrl_if: receiver byte stream in, register/status bus out
interface uart_rx_cmd_ctrl_if;
    logic        rx_dat_ready;
    logic [7:0]  rx_dat;
    logic        rx_receiving;
    logic [31:0] regs_o;
    logic        wr_pulse;
    logic [1:0]  wr_addr;
    logic        err_pulse;
    logic [7:0]  err_cnt;
    logic        busy;
    modport master (
        output rx_dat_ready, rx_dat, rx_receiving,
        input  regs_o, wr_pulse, wr_addr, err_pulse, err_cnt, busy
    );
    modport slave (
        input  rx_dat_ready, rx_dat, rx_receiving,
        output regs_o, wr_pulse, wr_addr, err_pulse, err_cnt, busy
    );
endinterface

// File: rtl/uart_rx_cmd_ctrl.sv
// uart_rx_cmd_ctrl: parses SYNC/ADDR/DATA/CHK frames into four 8-bit registers; optional inter-byte timeout via UART_RX_CMD_TIMEOUT_EN
module uart_rx_cmd_ctrl #(
    parameter logic [7:0] G_SYNC        = 8'hA5,
    parameter logic [7:0] G_RST_VAL     = 8'h00,
    parameter int         G_TIMEOUT_CYC = 12000
) (
    input logic               clk,
    input logic               rst,
    uart_rx_cmd_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_SYNC, S_ADDR, S_DATA, S_CHK} state_t;

    state_t      state;
    logic [1:0]  addr;
    logic [7:0]  data;
    logic [7:0]  sum;
    logic        pend_wr;
    logic        pend_err;
    logic [31:0] regs;
    logic        wr_pulse;
    logic [1:0]  wr_addr;
    logic        err_pulse;
    logic [7:0]  err_cnt;
    logic        timeout;

`ifdef UART_RX_CMD_TIMEOUT_EN
    localparam int TW = $clog2(G_TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_cnt;

    assign timeout = state != S_SYNC && !bus.rx_dat_ready && tmo_cnt == TW'(G_TIMEOUT_CYC);

    // idle-time counter, held at zero while hunting for SYNC or while a character is arriving
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tmo_cnt <= '0;
        else if (state == S_SYNC || bus.rx_dat_ready || bus.rx_receiving || timeout)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + 1'b1;
    end
`else
    logic unused_tmo;
    assign timeout    = 1'b0;
    assign unused_tmo = bus.rx_receiving ^ G_TIMEOUT_CYC[0];
`endif

    // frame parser; the verdict on a frame is registered and applied one edge later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_SYNC;
            addr      <= '0;
            data      <= '0;
            sum       <= '0;
            pend_wr   <= 1'b0;
            pend_err  <= 1'b0;
            regs      <= {4{G_RST_VAL}};
            wr_pulse  <= 1'b0;
            wr_addr   <= '0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
        end else begin
            pend_wr   <= 1'b0;
            pend_err  <= 1'b0;
            wr_pulse  <= pend_wr;
            err_pulse <= pend_err | timeout;
            if (pend_wr) begin
                regs[{addr, 3'b000} +: 8] <= data;
                wr_addr                   <= addr;
            end
            if ((pend_err | timeout) && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;
            if (timeout)
                state <= S_SYNC;
            else if (bus.rx_dat_ready) begin
                case (state)
                    S_SYNC: if (bus.rx_dat == G_SYNC) state <= S_ADDR;
                    S_ADDR: begin
                        addr <= bus.rx_dat[1:0];
                        sum  <= bus.rx_dat;
                        if (bus.rx_dat[7:2] != 6'd0) begin
                            pend_err <= 1'b1;
                            state    <= S_SYNC;
                        end else
                            state <= S_DATA;
                    end
                    S_DATA: begin
                        data  <= bus.rx_dat;
                        sum   <= sum + bus.rx_dat;
                        state <= S_CHK;
                    end
                    default: begin
                        pend_wr  <= bus.rx_dat == sum;
                        pend_err <= bus.rx_dat != sum;
                        state    <= S_SYNC;
                    end
                endcase
            end
        end
    end

    assign bus.regs_o    = regs;
    assign bus.wr_pulse  = wr_pulse;
    assign bus.wr_addr   = wr_addr;
    assign bus.err_pulse = err_pulse;
    assign bus.err_cnt   = err_cnt;
    assign bus.busy      = state != S_SYNC;
endmodule

// File: tb/tb_uart_rx_cmd_ctrl.sv
// tb_uart_rx_cmd_ctrl: directed and random frames checked every cycle against a frame-level model
module tb_uart_rx_cmd_ctrl;
    localparam int T = 100;

    logic clk = 1'b0;
    logic rst;
    bit   cmp_en = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    uart_rx_cmd_ctrl_if bus();

    uart_rx_cmd_ctrl #(.G_SYNC(8'hA5), .G_RST_VAL(8'h00), .G_TIMEOUT_CYC(T)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // model state: bytes of the current frame seen so far, verdict due next edge, visible outputs
    logic [7:0] m_regs [4];
    int         m_len;
    int         f_addr, f_data;
    int         p_kind, p_addr, p_data;
    bit         m_wr, m_ep, tmo;
    int         m_wa, m_err, idle;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
        m_len = 0; p_kind = 0; m_wr = 0; m_ep = 0; m_wa = 0; m_err = 0; idle = 0;
    endtask

    task automatic take(input int b);
        case (m_len)
            0: if (b == 'hA5) m_len = 1;
            1: begin
                f_addr = b;
                if (b > 3) begin p_kind = 2; m_len = 0; end
                else m_len = 2;
            end
            2: begin f_data = b; m_len = 3; end
            default: begin
                if (b == (f_addr + f_data) % 256) begin
                    p_kind = 1; p_addr = f_addr; p_data = f_data;
                end else p_kind = 2;
                m_len = 0;
            end
        endcase
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else begin
            m_wr = 0;
            m_ep = 0;
            if (p_kind == 1) begin m_regs[p_addr] = p_data[7:0]; m_wa = p_addr; m_wr = 1; end
            if (p_kind == 2) m_ep = 1;
            p_kind = 0;
            tmo = 0;
`ifdef UART_RX_CMD_TIMEOUT_EN
            tmo  = m_len > 0 && !bus.rx_dat_ready && idle == T;
            idle = (m_len == 0 || bus.rx_dat_ready || bus.rx_receiving || tmo) ? 0 : idle + 1;
`endif
            if (tmo) begin m_ep = 1; m_len = 0; end
            else if (bus.rx_dat_ready) take(int'(bus.rx_dat));
            if (m_ep && m_err < 255) m_err++;
        end
    end

    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            chk("regs", bus.regs_o, {m_regs[3], m_regs[2], m_regs[1], m_regs[0]});
            chk("wr_pulse", 32'(bus.wr_pulse), 32'(m_wr));
            chk("wr_addr", 32'(bus.wr_addr), 32'(m_wa));
            chk("err_pulse", 32'(bus.err_pulse), 32'(m_ep));
            chk("err_cnt", 32'(bus.err_cnt), 32'(m_err));
            chk("busy", 32'(bus.busy), 32'(m_len != 0));
        end
    end

    task automatic send(input logic [7:0] b, input int gap);
        bus.rx_dat_ready = 1'b1;
        bus.rx_dat = b;
        @(negedge clk);
        if (gap > 0) begin
            bus.rx_dat_ready = 1'b0;
            bus.rx_dat = 8'($urandom);
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic quiet(input int n);
        bus.rx_dat_ready = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
        send(8'hA5, $urandom_range(0, 2));
        send(a, $urandom_range(0, 2));
        send(d, $urandom_range(0, 2));
        send(c, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        quiet(1);
    endtask

    initial begin
        logic [7:0] a, d;
        bus.rx_dat_ready = 1'b0;
        bus.rx_dat = 8'h00;
        bus.rx_receiving = 1'b0;
        rst = 1'b0;
        #1 rst = 1'b1;
        cmp_en = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_regs", bus.regs_o, 32'h0);
        chk("rst_err_cnt", 32'(bus.err_cnt), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_wr_addr", 32'(bus.wr_addr), 32'h0);
        quiet(2);

        send(8'hA5, 1); send(8'h02, 1); send(8'h3C, 1); send(8'h3E, 0);
        bus.rx_dat_ready = 1'b0;
        chk("t1_wr_edge_n", 32'(bus.wr_pulse), 32'h0);
        @(negedge clk);
        chk("t1_wr_edge_n1", 32'(bus.wr_pulse), 32'h1);
        chk("t1_wr_addr", 32'(bus.wr_addr), 32'h2);
        @(negedge clk);
        chk("t1_wr_once", 32'(bus.wr_pulse), 32'h0);
        chk("t1_regs", bus.regs_o, 32'h003C_0000);
        chk("t1_err_cnt", 32'(bus.err_cnt), 32'h0);

        frame(8'h01, 8'hFF, 8'h00);
        quiet(2);
        chk("t2_reg1", 32'(bus.regs_o[15:8]), 32'hFF);
        frame(8'h01, 8'h10, 8'h12);
        quiet(2);
        chk("t2_reg1_kept", 32'(bus.regs_o[15:8]), 32'hFF);
        chk("t2_err_cnt", 32'(bus.err_cnt), 32'h1);

        do_reset();
        send(8'h00, 1); send(8'h37, 0);
        frame(8'h03, 8'h81, 8'h84);
        quiet(2);
        chk("t3_reg3", 32'(bus.regs_o[31:24]), 32'h81);
        chk("t3_err_cnt", 32'(bus.err_cnt), 32'h0);

        send(8'hA5, 0); send(8'h04, 0);
        frame(8'h00, 8'h11, 8'h11);
        quiet(2);
        chk("t4_err_cnt", 32'(bus.err_cnt), 32'h1);
        chk("t4_reg0", 32'(bus.regs_o[7:0]), 32'h11);

        for (int i = 0; i < 257; i++) begin
            send(8'hA5, $urandom_range(0, 1));
            send(8'h04, $urandom_range(0, 2));
        end
        quiet(2);
        chk("t5_err_sat", 32'(bus.err_cnt), 32'hFF);
        send(8'hA5, 1); send(8'h00, 1);
        chk("t5_busy_mid", 32'(bus.busy), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_busy", 32'(bus.busy), 32'h0);
        chk("t5_rst_regs", bus.regs_o, 32'h0);
        chk("t5_rst_err", 32'(bus.err_cnt), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        quiet(1);

        send(8'hA5, 1); send(8'h00, 0);
        quiet(T + 20);
`ifdef UART_RX_CMD_TIMEOUT_EN
        chk("t6_tmo_err", 32'(bus.err_cnt), 32'h1);
        chk("t6_tmo_busy", 32'(bus.busy), 32'h0);
        send(8'hA5, 1); send(8'h01, T); send(8'h20, T); send(8'h21, 1);
        quiet(2);
        chk("t6_expiry_byte", 32'(bus.regs_o[15:8]), 32'h20);
`else
        chk("t6_no_tmo_err", 32'(bus.err_cnt), 32'h0);
        chk("t6_no_tmo_busy", 32'(bus.busy), 32'h1);
`endif
        do_reset();

        for (int i = 0; i < 300; i++) begin
            bus.rx_receiving = 1'($urandom);
            a = 8'($urandom_range(0, 3));
            d = 8'($urandom);
            case ($urandom_range(0, 4))
                0, 1: frame(a, d, a + d);
                2:    frame(a, d, a + d + 8'($urandom_range(1, 255)));
                3:    frame(8'($urandom_range(4, 255)), d, d);
                default: send(8'($urandom_range(0, 164)), $urandom_range(0, 3));
            endcase
        end
        quiet(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
